// File: rtl/basic_gates_unit.sv
// basic_gates_unit: registered two-input gate bank (AND/OR/NAND/NOR/XOR/XNOR).
// All six results and vld are registered, one cycle after an enabled sample.
// Optional feature macro: BASIC_GATES_SAMPLE_COUNT_EN adds a 16-bit saturating
// count of accepted samples on output sample_cnt.
module basic_gates_unit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] w3,
    output logic [WIDTH-1:0] p,
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
    output logic [15:0]      sample_cnt,
`endif
    output logic             vld
);

    localparam int unsigned CNT_W = 16;

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic             w_accept;

    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_nand;
    logic [WIDTH-1:0] r_nor;
    logic [WIDTH-1:0] r_xor;
    logic [WIDTH-1:0] r_xnor;
    logic             r_vld;

    // Bitwise gate functions; no cross-bit interaction.
    always_comb begin
        w_and    = a & b;
        w_or     = a | b;
        w_xor    = a ^ b;
        w_accept = en & ~rst;
    end

    // Result registers: cleared by reset (even the inverting gates), held when en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_and  <= '0;
            r_or   <= '0;
            r_nand <= '0;
            r_nor  <= '0;
            r_xor  <= '0;
            r_xnor <= '0;
        end else if (en) begin
            r_and  <= w_and;
            r_or   <= w_or;
            r_nand <= ~w_and;
            r_nor  <= ~w_or;
            r_xor  <= w_xor;
            r_xnor <= ~w_xor;
        end
    end

    // One-cycle valid pulse per accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= en;
        end
    end

`ifdef BASIC_GATES_SAMPLE_COUNT_EN
    logic [CNT_W-1:0] r_sample_cnt;

    // Saturating count of accepted samples, updated on the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (w_accept && (r_sample_cnt != {CNT_W{1'b1}})) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end
    end

    assign sample_cnt = r_sample_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = w_accept & (CNT_W != 0);
`endif

    assign y   = r_and;
    assign w1  = r_or;
    assign w2  = r_nand;
    assign z   = r_nor;
    assign w3  = r_xor;
    assign p   = r_xnor;
    assign vld = r_vld;

endmodule

// File: tb/tb_basic_gates_unit.sv
// Scoreboard bench for basic_gates_unit: a 1-bit and an 8-bit instance share
// rst/en; expected results come from a per-bit counting model.
module tb_basic_gates_unit;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [7:0] z;
        logic [7:0] w3;
        logic [7:0] p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       a1  = 1'b0;
    logic       b1  = 1'b0;
    logic [7:0] a8  = 8'h00;
    logic [7:0] b8  = 8'h00;

    logic       y1, w1_1, w2_1, z1, w3_1, p1, vld1;
    logic [7:0] y8, w1_8, w2_8, z8, w3_8, p8;
    logic       vld8;
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
    logic [15:0] cnt1, cnt8;
    int          cnt_m = 0;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q [2][$];
    exp_t held [2];
    logic armed = 1'b0;
    logic rst_q = 1'b0;

    always #5 clk = ~clk;

    basic_gates_unit u_dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1),
        .y(y1), .w1(w1_1), .w2(w2_1), .z(z1), .w3(w3_1), .p(p1),
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
        .sample_cnt(cnt1),
`endif
        .vld(vld1)
    );

    basic_gates_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8),
        .y(y8), .w1(w1_8), .w2(w2_8), .z(z8), .w3(w3_8), .p(p8),
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
        .sample_cnt(cnt8),
`endif
        .vld(vld8)
    );

    // Gate results from the count of ones at each bit position.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int w);
        exp_t e;
        int   s;
        e = '0;
        for (int i = 0; i < w; i++) begin
            s = (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
            e.y[i]  = (s == 2);
            e.w1[i] = (s >= 1);
            e.w2[i] = (s != 2);
            e.z[i]  = (s == 0);
            e.w3[i] = (s == 1);
            e.p[i]  = (s != 1);
        end
        return e;
    endfunction

    task automatic compare(input string name, input int k, input exp_t got, input logic gv,
                           input exp_t exp, input logic ev);
        checks++;
        if (got !== exp || gv !== ev) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got y=%h w1=%h w2=%h z=%h w3=%h p=%h vld=%b exp y=%h w1=%h w2=%h z=%h w3=%h p=%h vld=%b",
                     name, k, $time, got.y, got.w1, got.w2, got.z, got.w3, got.p, gv,
                     exp.y, exp.w1, exp.w2, exp.z, exp.w3, exp.p, ev);
        end
    endtask

    // Apply one cycle of stimulus and push expected responses for enabled samples.
    task automatic drive(input logic r, input logic e, input logic x1, input logic v1,
                         input logic [7:0] x8, input logic [7:0] v8);
        @(negedge clk);
        rst = r; en = e; a1 = x1; b1 = v1; a8 = x8; b8 = v8;
        if (!r && e) begin
            q[0].push_back(model({7'b0, x1}, {7'b0, v1}, 1));
            q[1].push_back(model(x8, v8, 8));
        end
    endtask

    // Reference view of reset and sample count at each edge.
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) armed <= 1'b1;
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
        if (rst) cnt_m <= 0;
        else if (en && cnt_m < 65535) cnt_m <= cnt_m + 1;
`endif
    end

    // Monitor: pops expected results when vld, otherwise expects held/reset values.
    always @(negedge clk) begin
        exp_t got [2];
        logic gv [2];
        if (armed) begin
            got[0] = '{y: {7'b0, y1}, w1: {7'b0, w1_1}, w2: {7'b0, w2_1},
                       z: {7'b0, z1}, w3: {7'b0, w3_1}, p: {7'b0, p1}};
            got[1] = '{y: y8, w1: w1_8, w2: w2_8, z: z8, w3: w3_8, p: p8};
            gv[0] = vld1;
            gv[1] = vld8;
            for (int k = 0; k < 2; k++) begin
                if (rst_q) begin
                    held[k] = '0;
                    compare("reset", k, got[k], gv[k], '0, 1'b0);
                end else if (gv[k] === 1'b1) begin
                    if (q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vld dut%0d t=%0t got vld=1 exp vld=0", k, $time);
                    end else begin
                        held[k] = q[k].pop_front();
                        compare("result", k, got[k], gv[k], held[k], 1'b1);
                    end
                end else begin
                    compare("hold", k, got[k], gv[k], held[k], 1'b0);
                end
            end
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
            checks += 2;
            if (cnt1 !== 16'(cnt_m) || cnt8 !== 16'(cnt_m)) begin
                errors++;
                $display("FAIL sample_cnt t=%0t got %h/%h exp %h", $time, cnt1, cnt8, 16'(cnt_m));
            end
`endif
        end
    end

    initial begin
        // Reset held two cycles with all-ones operands and en=1.
        drive(1, 1, 1, 1, 8'hFF, 8'hFF);
        drive(1, 1, 1, 1, 8'hFF, 8'hFF);
        drive(0, 1, 1, 1, 8'hFF, 8'hFF);
        // Truth table plus the 8-bit F0/AA pattern.
        drive(0, 1, 0, 0, 8'hF0, 8'hAA);
        drive(0, 1, 0, 1, 8'h00, 8'hFF);
        drive(0, 1, 1, 0, 8'hFF, 8'h00);
        drive(0, 1, 1, 1, 8'h0F, 8'h3C);
        // Hold: capture (1,0) then en=0 with changed operands.
        drive(0, 1, 1, 0, 8'hF0, 8'hAA);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 8'h12, 8'h34);
        // Reset in the middle of an enabled stream.
        drive(0, 1, 0, 1, 8'h5A, 8'hC3);
        drive(0, 1, 1, 1, 8'h77, 8'h81);
        drive(1, 1, 1, 0, 8'h99, 8'h66);
        drive(0, 1, 1, 0, 8'hF0, 8'hAA);
        drive(0, 1, 0, 0, 8'h01, 8'h80);
        // Randomized traffic with occasional reset and gaps.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end
`ifdef BASIC_GATES_SAMPLE_COUNT_EN
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) drive(0, 1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 65540; i++) drive(0, 1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
`endif
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d got %0d pending exp 0", k, q[k].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/basic_gates_unit.md
Name: basic_gates_unit

Overview:
- Registered two-input logic-gate bank.
- Applies AND, OR, NAND, NOR, XOR and XNOR bitwise to operands a and b.
- Presents all six results on registered outputs one clock after sampling.
- Used as the elementary logic reference block in the digital-electronics lab datapath. Default width is 1 bit, so it drops in where a single-bit gate set is expected.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; operands are captured only when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  registered a AND b.
- w1  output  WIDTH  registered a OR b.
- w2  output  WIDTH  registered a NAND b.
- z  output  WIDTH  registered a NOR b.
- w3  output  WIDTH  registered a XOR b.
- p  output  WIDTH  registered a XNOR b.
- vld  output  1  high for one cycle after each accepted sample.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high: on a rising clk edge with rst=1, y, w1, w2, z, w3, p are all cleared to 0 and vld to 0.
  - This holds even though NAND/NOR/XNOR of zeros would be 1.
  - rst has priority over en.
- Latency: exactly 1 cycle.
  - On a rising edge with rst=0 and en=1, every output bit i becomes the gate function of a[i], b[i] sampled at that edge.
  - vld is 1 in the following cycle.
- Hold: on an edge with rst=0 and en=0, all six result outputs hold their previous value and vld goes to 0.
- Bit independence: each bit position is computed only from the same bit of a and b; there is no carry or cross-bit interaction.
- Consistency: outside reset, for every bit the following always hold:
  - w2 = ~y
  - z = ~w1
  - p = ~w3
  - y | w3 = w1
- Reset mid-stream: results captured before reset are discarded. The first vld after reset release corresponds to the first en=1 edge with rst=0.
- X/Z on a or b is not required to be handled; operands are assumed driven whenever en=1.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro BASIC_GATES_SAMPLE_COUNT_EN.
- When defined:
  - Adds output sample_cnt (16 bits) counting accepted samples (edges with en=1, rst=0).
  - The counter saturates at 16'hFFFF and is cleared to 0 by rst.
  - It updates on the same edge that captures the operands.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with a=1, b=1, en=1 -> y=w1=w2=z=w3=p=0 and vld=0 throughout; release rst -> first edge with en=1 gives y=1, w1=1, w2=0, z=0, w3=0, p=1, vld=1.
- Full truth table at WIDTH=1 with en=1, one operand pair per cycle (results appear one cycle later):
  - a=0, b=0 -> y=0, w1=0, w2=1, z=1, w3=0, p=1.
  - a=0, b=1 -> y=0, w1=1, w2=1, z=0, w3=1, p=0.
  - a=1, b=0 -> same as a=0, b=1.
  - a=1, b=1 -> y=1, w1=1, w2=0, z=0, w3=0, p=1.
- Hold: capture a=1, b=0, then drive en=0 and change to a=1, b=1 for 3 cycles -> outputs stay at the (1,0) results and vld=0 for those cycles.
- Width: WIDTH=8, a=8'hF0, b=8'hAA -> y=8'hA0, w1=8'hFA, w2=8'h5F, z=8'h05, w3=8'h5A, p=8'hA5.
- Reset mid-operation: en=1 with changing operands, assert rst for 1 cycle -> outputs 0 on the next edge; the next sample after release is correct.
- With BASIC_GATES_SAMPLE_COUNT_EN: 5 enabled samples, then 2 with en=0 -> sample_cnt=5; force 65540 enabled samples -> sample_cnt=16'hFFFF.
